// File: rtl/uart_pattern_gen.sv
// uart_pattern_gen: test-pattern word source for the UART transmit path.
// Produces INC / FIXED / PRBS / WALK1 words over a valid/ready handshake.
// Bursts are finite (BURST_LEN words) or continuous, with GAP_CYCLES idle
// cycles between accepted words.
// Optional feature: define UART_PATGEN_CHECKSUM_EN to append one XOR
// checksum beat after the last data word of a finite burst.
module uart_pattern_gen #(
    parameter int         DATA_BIT   = 8,
    parameter logic [7:0] SEED       = 8'h5A,
    parameter int         BURST_LEN  = 0,
    parameter int         GAP_CYCLES = 0
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic [1:0]          i_mode,
    output logic [DATA_BIT-1:0] o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_last,
    output logic                o_done,
    output logic                o_busy,
    output logic [15:0]         o_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_FIXED = 2'd1;
    localparam logic [1:0] MODE_PRBS  = 2'd2;
    localparam logic [1:0] MODE_WALK1 = 2'd3;

`ifdef UART_PATGEN_CHECKSUM_EN
    localparam bit CKS_EN = (BURST_LEN != 0);
`else
    localparam bit CKS_EN = 1'b0;
`endif

    localparam logic [DATA_BIT-1:0] SEED_W = SEED[DATA_BIT-1:0];
    localparam logic [DATA_BIT-1:0] ONE_W  = {{(DATA_BIT-1){1'b0}}, 1'b1};
    localparam bit                  FINITE = (BURST_LEN != 0);
    localparam bit                  HAS_GAP = (GAP_CYCLES != 0);
    // o_last marks the final data word only when no checksum beat follows it.
    localparam bit                  DATA_LAST  = FINITE && !CKS_EN;
    localparam bit                  FIRST_LAST = DATA_LAST && (BURST_LEN == 1);
    localparam logic [15:0]         LAST_IDX = 16'(BURST_LEN - 1);
    localparam logic [7:0]          GAP_LOAD = 8'(GAP_CYCLES - 1);

    // First word of a burst for the given pattern.
    function automatic logic [DATA_BIT-1:0] init_word(input logic [1:0] mode);
        logic [DATA_BIT-1:0] w;
        case (mode)
            MODE_PRBS:  w = (SEED_W == '0) ? ONE_W : SEED_W;
            MODE_WALK1: w = ONE_W;
            default:    w = SEED_W;
        endcase
        return w;
    endfunction

    // Fibonacci LFSR step: shift left, feedback into bit 0.
    function automatic logic [DATA_BIT-1:0] prbs_next(input logic [DATA_BIT-1:0] w);
        logic [7:0] w8;
        logic       fb;
        w8 = 8'(w);
        case (DATA_BIT)
            32'd5:   fb = w8[4] ^ w8[2];
            32'd6:   fb = w8[5] ^ w8[4];
            32'd7:   fb = w8[6] ^ w8[5];
            default: fb = w8[7] ^ w8[5] ^ w8[4] ^ w8[3];
        endcase
        return {w[DATA_BIT-2:0], fb};
    endfunction

    // Word following w in the latched pattern.
    function automatic logic [DATA_BIT-1:0] next_word(input logic [1:0] mode,
                                                      input logic [DATA_BIT-1:0] w);
        logic [DATA_BIT-1:0] n;
        case (mode)
            MODE_INC:   n = w + ONE_W;
            MODE_FIXED: n = w;
            MODE_PRBS:  n = prbs_next(w);
            MODE_WALK1: n = {w[DATA_BIT-2:0], w[DATA_BIT-1]};
            default:    n = w;
        endcase
        return n;
    endfunction

    // Running XOR checksum of the data words.
    function automatic logic [DATA_BIT-1:0] cks_fold(input logic [DATA_BIT-1:0] acc,
                                                     input logic [DATA_BIT-1:0] w);
        return acc ^ w;
    endfunction

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_BIT-1:0] data_q, data_d;
    logic [DATA_BIT-1:0] cks_q, cks_d;
    logic                cks_beat_q, cks_beat_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [15:0]         count_q, count_d;
    logic [7:0]          gap_q, gap_d;
    logic                xfer_s;
    logic                final_s;

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        data_d     = data_q;
        cks_d      = cks_q;
        cks_beat_d = cks_beat_q;
        valid_d    = valid_q;
        last_d     = last_q;
        done_d     = 1'b0;
        count_d    = count_q;
        gap_d      = gap_q;
        xfer_s     = valid_q & i_ready;
        final_s    = FINITE && (count_q == LAST_IDX);

        case (state_q)
            ST_IDLE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (i_enable) begin
                    state_d    = ST_SEND;
                    mode_d     = i_mode;
                    data_d     = init_word(i_mode);
                    valid_d    = 1'b1;
                    last_d     = FIRST_LAST;
                    count_d    = 16'd0;
                    cks_d      = '0;
                    cks_beat_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SEND: begin
                valid_d = 1'b1;
                if (!xfer_s) begin
                    // Word held stable until accepted, regardless of i_enable.
                    state_d = ST_SEND;
                end else if (cks_beat_q) begin
                    state_d    = ST_DONE;
                    valid_d    = 1'b0;
                    last_d     = 1'b0;
                    done_d     = 1'b1;
                    cks_beat_d = 1'b0;
                end else begin
                    count_d = count_q + 16'd1;
                    cks_d   = cks_fold(cks_q, data_q);
                    if (final_s && CKS_EN) begin
                        // Checksum beat follows immediately, never gapped.
                        cks_beat_d = 1'b1;
                        data_d     = cks_fold(cks_q, data_q);
                        last_d     = 1'b1;
                    end else if (final_s) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d = next_word(mode_q, data_q);
                        last_d = DATA_LAST && ((count_q + 16'd1) == LAST_IDX);
                        if (!i_enable) begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                        end else if (HAS_GAP) begin
                            state_d = ST_GAP;
                            valid_d = 1'b0;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = ST_SEND;
                        end
                    end
                end
            end

            ST_GAP: begin
                valid_d = 1'b0;
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (gap_q == 8'd0) begin
                    state_d = ST_SEND;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end

            ST_DONE: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_INC;
            data_q     <= '0;
            cks_q      <= '0;
            cks_beat_q <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= 16'd0;
            gap_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            data_q     <= data_d;
            cks_q      <= cks_d;
            cks_beat_q <= cks_beat_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_done  = done_q;
    assign o_busy  = busy_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Bench for uart_pattern_gen: three instances (finite INC burst, continuous
// wrap/walk, continuous PRBS with gap) checked every cycle against a
// beat-indexed pattern model, plus literal expectations.
module tb_uart_pattern_gen;

    localparam logic [7:0] P_SEED [3] = '{8'h5A, 8'hFE, 8'h00};
    localparam int         P_BLEN [3] = '{4, 0, 0};
    localparam int         P_GAP  [3] = '{0, 0, 3};
`ifdef UART_PATGEN_CHECKSUM_EN
    localparam bit TB_CKS = 1'b1;
`else
    localparam bit TB_CKS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en    [3];
    logic        rdy   [3];
    logic [1:0]  mode  [3];
    logic [7:0]  d_data  [3];
    logic        d_valid [3];
    logic        d_last  [3];
    logic        d_done  [3];
    logic        d_busy  [3];
    logic [15:0] d_count [3];

    uart_pattern_gen #(.DATA_BIT(8), .SEED(8'h5A), .BURST_LEN(4), .GAP_CYCLES(0)) u_a (
        .i_clk(clk), .i_reset(rst), .i_enable(en[0]), .i_mode(mode[0]),
        .o_data(d_data[0]), .o_valid(d_valid[0]), .i_ready(rdy[0]), .o_last(d_last[0]),
        .o_done(d_done[0]), .o_busy(d_busy[0]), .o_count(d_count[0]));

    uart_pattern_gen #(.DATA_BIT(8), .SEED(8'hFE), .BURST_LEN(0), .GAP_CYCLES(0)) u_b (
        .i_clk(clk), .i_reset(rst), .i_enable(en[1]), .i_mode(mode[1]),
        .o_data(d_data[1]), .o_valid(d_valid[1]), .i_ready(rdy[1]), .o_last(d_last[1]),
        .o_done(d_done[1]), .o_busy(d_busy[1]), .o_count(d_count[1]));

    uart_pattern_gen #(.DATA_BIT(8), .SEED(8'h00), .BURST_LEN(0), .GAP_CYCLES(3)) u_c (
        .i_clk(clk), .i_reset(rst), .i_enable(en[2]), .i_mode(mode[2]),
        .o_data(d_data[2]), .o_valid(d_valid[2]), .i_ready(rdy[2]), .o_last(d_last[2]),
        .o_done(d_done[2]), .o_busy(d_busy[2]), .o_count(d_count[2]));

    always #5 clk = ~clk;

    int         checks;
    int         failures;
    int         m_beat   [3];
    logic [1:0] m_mode   [3];
    logic [7:0] m_lfsr   [3];
    logic [7:0] m_cks    [3];
    bit         m_cks_ph [3];
    bit         m_active [3];
    bit         done_due [3];
    bit         stalled  [3];
    bit         after_x  [3];
    logic [7:0] st_data  [3];
    logic       st_last  [3];
    int         low_run  [3];
    logic [7:0] obs_log  [3][512];
    int         obs_n    [3];
    bit         seen     [256];
    int         zeros;
    int         distinct;
    bit         got;

    task automatic check(input int i, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL inst%0d %s: got %0h expected %0h", i, name, act, exp);
        end
    endtask

    // Fresh burst in the model: beat 0 of the given pattern.
    task automatic model_init(input int i, input logic [1:0] md);
        m_mode[i]   = md;
        m_beat[i]   = 0;
        m_lfsr[i]   = (P_SEED[i] == 8'h00) ? 8'h01 : P_SEED[i];
        m_cks[i]    = 8'h00;
        m_cks_ph[i] = 1'b0;
        m_active[i] = 1'b1;
        after_x[i]  = 1'b0;
        stalled[i]  = 1'b0;
        low_run[i]  = 0;
        obs_n[i]    = 0;
    endtask

    // Per-cycle comparison of all instances against the model.
    task automatic compare_all();
        logic [7:0] e_data;
        logic [7:0] one8;
        bit         e_last;
        bit         fin;
        bit         cks_i;
        one8 = 8'h01;
        for (int i = 0; i < 3; i++) begin
            cks_i = TB_CKS && (P_BLEN[i] != 0);
            if (rst) begin
                check(i, "reset_outputs", {d_data[i], d_count[i], d_valid[i], d_last[i],
                                           d_done[i], d_busy[i]}, 32'd0);
                model_init(i, m_mode[i]);
                done_due[i] = 1'b0;
            end else begin
                check(i, "done", d_done[i], done_due[i]);
                done_due[i] = 1'b0;
                if (stalled[i]) begin
                    check(i, "hold_valid", d_valid[i], 1'b1);
                    check(i, "hold_data", d_data[i], st_data[i]);
                    check(i, "hold_last", d_last[i], st_last[i]);
                end
                if (d_valid[i]) begin
                    check(i, "busy", d_busy[i], 1'b1);
                    if (!m_active[i]) begin
                        checks++;
                        failures++;
                        $display("FAIL inst%0d unexpected_valid: got 1 expected 0", i);
                    end
                    if (after_x[i]) begin
                        check(i, "gap_len", low_run[i], P_GAP[i]);
                        after_x[i] = 1'b0;
                    end
                    if (rdy[i]) begin
                        if (m_cks_ph[i]) begin
                            e_data = m_cks[i];
                            e_last = 1'b1;
                        end else begin
                            case (m_mode[i])
                                2'd0:    e_data = P_SEED[i] + 8'(m_beat[i]);
                                2'd1:    e_data = P_SEED[i];
                                2'd2:    e_data = m_lfsr[i];
                                default: e_data = one8 << (m_beat[i] % 8);
                            endcase
                            e_last = (P_BLEN[i] != 0) && !cks_i && (m_beat[i] == P_BLEN[i] - 1);
                        end
                        check(i, "data", d_data[i], e_data);
                        check(i, "last", d_last[i], e_last);
                        check(i, "count", d_count[i], 16'(m_beat[i]));
                        if (obs_n[i] < 512) obs_log[i][obs_n[i]] = d_data[i];
                        obs_n[i]++;
                        if (m_cks_ph[i]) begin
                            m_cks_ph[i] = 1'b0;
                            m_active[i] = 1'b0;
                            done_due[i] = 1'b1;
                        end else begin
                            fin = (P_BLEN[i] != 0) && (m_beat[i] == P_BLEN[i] - 1);
                            m_cks[i]  = m_cks[i] ^ e_data;
                            m_beat[i] = m_beat[i] + 1;
                            m_lfsr[i] = {m_lfsr[i][6:0], ^(m_lfsr[i] & 8'hB8)};
                            if (fin && cks_i) begin
                                m_cks_ph[i] = 1'b1;
                            end else if (fin) begin
                                m_active[i] = 1'b0;
                                done_due[i] = 1'b1;
                            end else begin
                                after_x[i] = 1'b1;
                                low_run[i] = 0;
                            end
                        end
                    end
                    stalled[i] = !rdy[i];
                    st_data[i] = d_data[i];
                    st_last[i] = d_last[i];
                end else begin
                    stalled[i] = 1'b0;
                    low_run[i] = low_run[i] + 1;
                end
            end
        end
    endtask

    task automatic start(input int i, input logic [1:0] md);
        @(posedge clk); #1 en[i] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        model_init(i, md);
        mode[i] = md;
        en[i]   = 1'b1;
    endtask

    task automatic stop(input int i);
        @(posedge clk); #1 en[i] = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_done(input int i, input int budget);
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (d_done[i]) got = 1'b1;
        end
        check(i, "wait_done", got, 1'b1);
    endtask

    task automatic wait_valid(input int i, input int budget);
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (d_valid[i]) got = 1'b1;
        end
        check(i, "wait_valid", got, 1'b1);
    endtask

    task automatic wait_obs(input int i, input int n, input int budget);
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (obs_n[i] >= n) got = 1'b1;
        end
        check(i, "wait_obs", got, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; rdy[i] = 1'b0; mode[i] = 2'd0;
            done_due[i] = 1'b0;
            model_init(i, 2'd0);
        end
        #2 rst = 1'b1;
        fork
            forever begin
                @(negedge clk);
                compare_all();
            end
        join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // INC burst of 4 with i_ready held high.
        rdy[0] = 1'b1;
        start(0, 2'd0);
        wait_done(0, 40);
        check(0, "inc_beats", obs_n[0], TB_CKS ? 32'd5 : 32'd4);
        check(0, "inc_w0", obs_log[0][0], 8'h5A);
        check(0, "inc_w1", obs_log[0][1], 8'h5B);
        check(0, "inc_w2", obs_log[0][2], 8'h5C);
        check(0, "inc_w3", obs_log[0][3], 8'h5D);
        if (TB_CKS) check(0, "inc_cks", obs_log[0][4], 8'h00);
        check(0, "inc_count", d_count[0], 16'd4);

        // Backpressure: three refused cycles on 0x5B.
        @(posedge clk); #1 rdy[0] = 1'b0;
        start(0, 2'd0);
        wait_valid(0, 20);
        @(posedge clk); #1 rdy[0] = 1'b1;
        @(posedge clk); #1 rdy[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check(0, "bp_valid", d_valid[0], 1'b1);
            check(0, "bp_data", d_data[0], 8'h5B);
        end
        @(posedge clk); #1 rdy[0] = 1'b1;
        wait_done(0, 40);
        check(0, "bp_w1", obs_log[0][1], 8'h5B);
        check(0, "bp_w2", obs_log[0][2], 8'h5C);
        check(0, "bp_w3", obs_log[0][3], 8'h5D);

        // Asynchronous reset while beat 2 is presented, then restart.
        @(posedge clk); #1 rdy[0] = 1'b0;
        start(0, 2'd0);
        wait_valid(0, 20);
        @(posedge clk); #1 rdy[0] = 1'b1;
        @(posedge clk); #1 rdy[0] = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check(0, "rst_valid", d_valid[0], 1'b0);
        check(0, "rst_count", d_count[0], 16'd0);
        @(posedge clk); #1 rst = 1'b0; rdy[0] = 1'b1;
        wait_done(0, 40);
        check(0, "rst_w0", obs_log[0][0], 8'h5A);
        check(0, "rst_w3", obs_log[0][3], 8'h5D);

        // INC wrap from 0xFE.
        rdy[1] = 1'b1;
        start(1, 2'd0);
        wait_obs(1, 4, 40);
        stop(1);
        check(1, "wrap_w0", obs_log[1][0], 8'hFE);
        check(1, "wrap_w1", obs_log[1][1], 8'hFF);
        check(1, "wrap_w2", obs_log[1][2], 8'h00);

        // WALK1 ignores SEED and rotates through all bits.
        start(1, 2'd3);
        wait_obs(1, 10, 40);
        stop(1);
        check(1, "walk_w0", obs_log[1][0], 8'h01);
        check(1, "walk_w7", obs_log[1][7], 8'h80);
        check(1, "walk_w8", obs_log[1][8], 8'h01);

        // PRBS from SEED 0, with three-cycle gaps.
        rdy[2] = 1'b1;
        start(2, 2'd2);
        wait_obs(2, 256, 1500);
        check(2, "prbs_w0", obs_log[2][0], 8'h01);
        check(2, "prbs_w1", obs_log[2][1], 8'h02);
        check(2, "prbs_w3", obs_log[2][3], 8'h08);
        check(2, "prbs_w4", obs_log[2][4], 8'h11);
        check(2, "prbs_w255", obs_log[2][255], 8'h01);
        zeros = 0;
        distinct = 0;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 255; k++) begin
            if (obs_log[2][k] == 8'h00) zeros++;
            if (!seen[obs_log[2][k]]) distinct++;
            seen[obs_log[2][k]] = 1'b1;
        end
        check(2, "prbs_zeros", zeros, 32'd0);
        check(2, "prbs_distinct", distinct, 32'd255);

        // Drop i_enable during a gap.
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (d_valid[2] && rdy[2]) got = 1'b1;
        end
        check(2, "gap_xfer_seen", got, 1'b1);
        @(posedge clk); #1 en[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(2, "gap_drop_busy", d_busy[2], 1'b0);
        got = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (d_valid[2]) got = 1'b1;
        end
        check(2, "gap_drop_novalid", got, 1'b0);

        // FIXED pattern repeats SEED.
        start(0, 2'd1);
        wait_done(0, 40);
        check(0, "fixed_w3", obs_log[0][3], 8'h5A);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
